// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Multi-read-port integer register file with per-register pending
//   (scoreboard) bits and a sequential bulk-clear engine. Decode reads
//   operands and reserves destinations. Writeback writes results and
//   releases those reservations.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     When defined, a writeback in the current cycle is forwarded to any
//     read port that addresses the same non-zero register. The same port
//     also shows the released pending bit. When undefined, read ports show
//     the array contents until the write edge.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   read_address   NREAD packed addresses, port k at [k*AW +: AW]
//   read_data      NREAD packed data words, port k at [k*XLEN +: XLEN]
//   read_pending   pending bit of the register seen by each read port
//   write_*        writeback port (strobe, destination, value)
//   issue_*        destination reservation from decode
//   clear_req      start a bulk clear of all registers and pending bits
//   clear_busy     clear engine running; writes and issues are dropped
//   clear_done     one-cycle pulse when the clear has finished
//
// Handshake: there is no back-pressure. write_enable and issue_enable are
// single-cycle strobes that take effect at the next rising edge. While
// clear_busy is high they are discarded. clear_req is sampled only while
// the engine is idle. Requests made during a clear or its done cycle are
// dropped, not queued.
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREAD*$clog2(NREGS)-1:0] read_address,
    output logic [NREAD*XLEN-1:0]         read_data,
    output logic [NREAD-1:0]              read_pending,
    input  logic                          write_enable,
    input  logic [$clog2(NREGS)-1:0]      write_address,
    input  logic [XLEN-1:0]               write_data,
    input  logic                          issue_enable,
    input  logic [$clog2(NREGS)-1:0]      issue_address,
    input  logic                          clear_req,
    output logic                          clear_busy,
    output logic                          clear_done
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   count_q;
    logic            clear_busy_q;
    logic            clear_done_q;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    logic            wr_go;
    logic            iss_go;

    // The clear engine owns the array while busy, so the ports are gated off.
    assign wr_go  = write_enable && !clear_busy_q;
    assign iss_go = issue_enable && !clear_busy_q && (issue_address != '0);

    // Next-state of the array and scoreboard.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wr_go && (write_address != '0)) begin
            regs_d[write_address] = write_data;
        end
        if (wr_go) begin
            pending_d[write_address] = 1'b0;
        end
        // Applied after the release so a same-edge re-issue keeps the
        // register reserved for the newer producer.
        if (iss_go) begin
            pending_d[issue_address] = 1'b1;
        end
        if (state_q == ST_CLEAR) begin
            regs_d[count_q]    = '0;
            pending_d[count_q] = 1'b0;
        end
        regs_d[0]    = '0;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q <= pending_d;
        end
    end

    // Clear engine: walks x1..x(NREGS-1), one register per cycle. x0 is
    // never written, so it needs no clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clear_req) begin
                        state_q      <= ST_CLEAR;
                        count_q      <= AW'(1);
                        clear_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (count_q == AW'(NREGS - 1)) begin
                        state_q      <= ST_DONE;
                        count_q      <= '0;
                        clear_busy_q <= 1'b0;
                        clear_done_q <= 1'b1;
                    end else begin
                        count_q <= count_q + AW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;

    // Combinational read ports.
    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rp;

        assign ra = read_address[k*AW +: AW];

        always_comb begin
            rd = regs_q[ra];
            rp = pending_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_go && (write_address == ra)) begin
                rd = write_data;
                rp = iss_go && (issue_address == ra);
            end
`endif
            if (ra == '0) begin
                rd = '0;
                rp = 1'b0;
            end
        end

        assign read_data[k*XLEN +: XLEN] = rd;
        assign read_pending[k]           = rp;
    end

endmodule
